// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR sample buffer.
package fir_pkg;
   localparam int SAMPLE_W  = 18;
   localparam int NUM_TAPS  = 16384;
   localparam int ADDR_W    = 12;
   localparam int PTR_W     = 14;
   localparam int NUM_BANKS = 4;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_START = 3'd3,
      ST_BUSY  = 3'd4
   } state_t;

   // Bank that feeds read lane 'lane' when the newest sample sits in bank 'rot'.
   function automatic logic [1:0] lane_bank(input logic [1:0] rot, input logic [1:0] lane);
      return 2'(rot - lane);
   endfunction
endpackage

// File: rtl/sample_bank.sv
// One 4096 x 18 simple dual-port RAM: one write port, one registered read port.
module sample_bank
   import fir_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_we,
   input  logic [ADDR_W-1:0]   i_waddr,
   input  logic [SAMPLE_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0]   i_raddr,
   output logic [SAMPLE_W-1:0] o_rdata
);
   logic [SAMPLE_W-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [SAMPLE_W-1:0] r_rdata;

   // Storage array carries no reset; only the post-reset sweep initialises it.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register (read-before-write on an address collision).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/sample_buffer.sv
// 16384-tap circular sample store for the FIR: four interleaved banks read as one
// 72-bit word of four consecutive-age samples, with a one-entry pending input slot.
module sample_buffer
   import fir_pkg::*;
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic signed [SAMPLE_W-1:0]   sample_in,
   input  logic                         sample_valid,
   output logic                         datain_ready,
   input  logic        [ADDR_W-1:0]     addr_data,
   output logic        [4*SAMPLE_W-1:0] datain,
   input  logic                         dataout_ready,
   output logic                         overrun,
   output logic                         clearing
);
   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_W-1:0]     r_clr_cnt;
   logic [PTR_W-1:0]      r_ptr;
   logic [PTR_W-1:0]      w_ptr_inc;
   logic                  r_pend_full;
   logic [SAMPLE_W-1:0]   r_pend_data;
   logic [SAMPLE_W-1:0]   r_wr_data;
   logic                  r_datain_ready;
   logic                  r_overrun;
   logic                  r_clearing;
   logic [1:0]            r_rot;
   logic                  w_to_write;
   logic                  w_take_pend;
   logic                  w_direct;
   logic [3:0]            w_bank_we;
   logic [ADDR_W-1:0]     w_bank_waddr;
   logic [SAMPLE_W-1:0]   w_bank_wdata;
   logic [ADDR_W-1:0]     w_rd_word;
   logic [SAMPLE_W-1:0]   w_bank_rdata [0:3];
   logic [4*SAMPLE_W-1:0] w_datain;

   assign w_ptr_inc = r_ptr + 14'd1;
   assign w_rd_word = r_ptr[PTR_W-1:2] - addr_data;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == 12'hFFF) w_next_state = ST_IDLE;
            else                      w_next_state = ST_CLEAR;
         end
         ST_IDLE: begin
            if (r_pend_full || sample_valid) w_next_state = ST_WRITE;
            else                             w_next_state = ST_IDLE;
         end
         ST_WRITE: w_next_state = ST_START;
         ST_START: w_next_state = ST_BUSY;
         ST_BUSY: begin
            if (dataout_ready) w_next_state = r_pend_full ? ST_WRITE : ST_IDLE;
            else               w_next_state = ST_BUSY;
         end
         default: w_next_state = ST_CLEAR;
      endcase
   end

   // Output decode: bank write strobes and which sample the next WRITE stores.
   always_comb begin
      w_to_write   = (w_next_state == ST_WRITE);
      w_take_pend  = w_to_write & r_pend_full;
      w_direct     = w_to_write & ~r_pend_full;
      w_bank_we    = 4'b0000;
      w_bank_waddr = r_clr_cnt;
      w_bank_wdata = '0;
      case (r_state)
         ST_CLEAR: w_bank_we = 4'b1111;
         ST_WRITE: begin
            w_bank_we    = 4'b0001 << w_ptr_inc[1:0];
            w_bank_waddr = w_ptr_inc[PTR_W-1:2];
            w_bank_wdata = r_wr_data;
         end
         default: w_bank_we = 4'b0000;
      endcase
   end

   // Datapath: sweep counter, pointer, pending slot and sticky/strobe outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_clr_cnt      <= 12'd0;
         r_ptr          <= 14'h3FFF;
         r_pend_full    <= 1'b0;
         r_pend_data    <= 18'd0;
         r_wr_data      <= 18'd0;
         r_datain_ready <= 1'b0;
         r_overrun      <= 1'b0;
         r_clearing     <= 1'b1;
         r_rot          <= 2'd0;
      end else begin
         r_clearing     <= (w_next_state == ST_CLEAR);
         r_datain_ready <= (w_next_state == ST_START);
         r_rot          <= r_ptr[1:0];
         if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 12'd1;
         if (r_state == ST_WRITE) r_ptr <= w_ptr_inc;
         if (w_take_pend)   r_wr_data <= r_pend_data;
         else if (w_direct) r_wr_data <= sample_in;
         // A strobe coinciding with the pending slot being drained refills it.
         if (w_take_pend) begin
            if (sample_valid) r_pend_data <= sample_in;
            else              r_pend_full <= 1'b0;
         end else if (sample_valid && !w_direct) begin
            if (!r_pend_full) begin
               r_pend_full <= 1'b1;
               r_pend_data <= sample_in;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   // Bank b is one word behind the base row when it lies ahead of the newest sample.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [ADDR_W-1:0] w_raddr;
      assign w_raddr = w_rd_word - ((2'(b) > r_ptr[1:0]) ? 12'd1 : 12'd0);
      sample_bank u_bank (
         .i_clk   (clock),
         .i_rst   (reset),
         .i_we    (w_bank_we[b]),
         .i_waddr (w_bank_waddr),
         .i_wdata (w_bank_wdata),
         .i_raddr (w_raddr),
         .o_rdata (w_bank_rdata[b])
      );
   end

   // Rotate bank outputs so lane 0 is always the newest sample of the group.
   always_comb begin
      w_datain = '0;
      for (int j = 0; j < 4; j++) begin
         w_datain[(3-j)*SAMPLE_W +: SAMPLE_W] = w_bank_rdata[lane_bank(r_rot, 2'(j))];
      end
   end

   assign datain       = w_datain;
   assign datain_ready = r_datain_ready;
   assign overrun      = r_overrun;
   assign clearing     = r_clearing;
endmodule

// File: doc/sample_buffer.md
SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: sample_in  input  18  signed new audio sample.
REQ-005 Port: sample_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
REQ-006 Port: datain_ready  output  1  one-cycle pulse; the buffer holds a new sample and the FIR may start.
REQ-007 Port: addr_data  input  12  word address from the FIR; k selects taps 4k..4k+3.
REQ-008 Port: datain  output  72  four samples: [71:54]=x[n-4k], [53:36]=x[n-4k-1], [35:18]=x[n-4k-2], [17:0]=x[n-4k-3].
REQ-009 Port: dataout_ready  input  1  FIR completion pulse; ends the FIR busy window.
REQ-010 Port: overrun  output  1  sticky flag: a sample was dropped.
REQ-011 Port: clearing  output  1  high while the post-reset zero sweep runs.

Function
REQ-012 Storage SHALL be 4 banks of 4096 x 18 (16384 taps total); sample index s (14 bits) SHALL map to bank s[1:0], word s[13:2].
REQ-013 Newest-sample pointer N (14 bits) SHALL reset to 14'h3FFF; each write SHALL go to N+1, then N <= N+1, wrapping modulo 16384.
REQ-014 For a read, lane j (0..3) SHALL return index N-4k-j modulo 16384; bank b SHALL be addressed at word (N-4k-((N-b) mod 4))>>2, and the lanes SHALL be rotated by N[1:0] onto datain.
REQ-015 Read latency SHALL be one cycle: datain SHALL reflect the addr_data sampled at the previous rising edge.
REQ-016 FSM states SHALL be CLEAR, IDLE, WRITE, START and BUSY.
REQ-017 CLEAR SHALL write zero to word w of all banks for w = 0..4095, one word per cycle, then go to IDLE (4096 cycles); clearing SHALL be high throughout.
REQ-018 IDLE: if the pending register is full or sample_valid is high, the FSM SHALL go to WRITE.
REQ-019 WRITE SHALL store the sample (pending takes priority over a live sample_in), update N, and go to START.
REQ-020 START SHALL pulse datain_ready for exactly one cycle and go to BUSY.
REQ-021 BUSY SHALL perform no bank writes; on dataout_ready the FSM SHALL go to IDLE, or directly to WRITE if the pending register is full.
REQ-022 A sample_valid in any state except IDLE SHALL be captured in a one-entry pending register; if that register is already full, the sample SHALL be dropped and overrun set.
REQ-023 A sample_valid in the same cycle that WRITE consumes the pending register SHALL refill it and SHALL NOT set overrun.
REQ-024 A sample_valid in IDLE with the pending register full SHALL be captured in place of the consumed entry; no sample SHALL be lost.
REQ-025 overrun SHALL be cleared only by reset.
REQ-026 addr_data values outside the FIR read window SHALL NOT affect state; reads SHALL have no side effects.

Reset
REQ-027 Reset SHALL force: state=CLEAR, clear counter=0, N=14'h3FFF, pending empty, datain_ready=0, overrun=0, clearing=1, and the datain register=0.
REQ-028 Reset asserted mid-operation (including mid-BUSY or mid-CLEAR) SHALL abort immediately and restart the full CLEAR sweep; bank contents need not be reset except by that sweep.

Structure
REQ-029 The shared package fir_pkg SHALL hold SAMPLE_W=18, NUM_TAPS=16384, ADDR_W=12, PTR_W=14 and the FSM state encoding.
REQ-030 A single sub-module, sample_bank, SHALL implement one 4096x18 simple dual-port RAM (one write port, one synchronous read port); it SHALL be instantiated 4 times.

Verification
REQ-031 Reset release -> clearing high for exactly 4096 cycles; all reads afterwards return 72'h0.
REQ-032 Write samples 1,2,3,4,5 (each followed by dataout_ready) -> with addr_data=0, datain = {5,4,3,2}; with addr_data=1, datain = {1,0,0,0}.
REQ-033 Write 16385 samples valued index+1 -> with addr_data=4095, datain lane 3 = 16385-16383 = 2; this checks wrap-around.
REQ-034 sample_valid in START, then again in BUSY -> the first is pending and the second sets overrun=1; after dataout_ready, exactly one extra datain_ready pulse.
REQ-035 sample_valid during CLEAR -> held in pending; datain_ready pulses within 3 cycles after clearing falls.
REQ-036 Reset asserted in BUSY -> datain_ready=0, overrun=0, clearing=1 the next cycle, and the sweep restarts.
